// File: rtl/ibex_avalon_data_bridge.sv
// ibex_avalon_data_bridge
//
// Bridges the Ibex data port (bus_data_* request/busy/rvalid/wrespvalid
// handshake) onto an Avalon-MM host port. Each accepted core request is
// held in a one-entry command register that drives the Avalon command
// signals directly. A credit counter tracks issued-but-unanswered
// transactions so responses can be returned to the core in order.
//
// Parameters
//   MAX_OUTSTANDING : max transactions in flight (power of 2, 1..16)
//   POSTED_WRITES   : 1 = write response generated locally on Avalon accept,
//                     0 = wait for avm_writeresponsevalid
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   bus_data_*   (core)     read/write request, addr/be/wdata in;
//                           busy, rvalid/rdata, wrespvalid, resp out
//   avm_*        (Avalon)   address/read/write/byteenable/writedata out;
//                           waitrequest, readdata(valid), writeresponsevalid,
//                           response in
//   proto_err_o             sticky: response seen with nothing outstanding

module ibex_avalon_data_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          POSTED_WRITES   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        bus_data_read,
    input  logic        bus_data_write,
    input  logic [31:0] bus_data_addr,
    input  logic [3:0]  bus_data_be,
    input  logic [31:0] bus_data_wdata,
    output logic        bus_data_busy,
    output logic        bus_data_rvalid,
    output logic [31:0] bus_data_rdata,
    output logic        bus_data_wrespvalid,
    output logic [1:0]  bus_data_resp,

    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_writeresponsevalid,
    input  logic [1:0]  avm_response,

    output logic        proto_err_o
);

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    // Command stage
    logic        cmd_valid_q;
    logic        cmd_we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    // Kind of the most recently accepted request (0 = read, 1 = write)
    logic        kind_q;

    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] pending;

    // Core-side response registers
    logic        rvalid_q;
    logic        wresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;
    logic        err_q;

    logic req, accept, issue;
    logic inc, dec;
    logic rsp_in, any_out;
    logic rd_fwd, wr_fwd;

    assign req     = bus_data_read | bus_data_write;
    assign issue   = cmd_valid_q & ~avm_waitrequest;
    assign any_out = (outstanding_q != '0);

    // Count everything that still owes the core a response from the fabric;
    // a queued command counts too so it cannot overrun the credit limit.
    assign pending = outstanding_q + CW'(cmd_valid_q);

    // Mixing reads and writes in flight could reorder responses (posted
    // writes answer locally, reads answer from the slave), so a request of
    // the other kind waits until the bridge drains.
    assign bus_data_busy = (cmd_valid_q & avm_waitrequest)
                         | (pending == CW'(MAX_OUTSTANDING))
                         | ((pending != '0) & req & (bus_data_write != kind_q));

    assign accept = req & ~bus_data_busy;

    // Posted writes never get a fabric response, so they take no credit.
    assign inc    = issue & (~cmd_we_q | ~POSTED_WRITES);
    assign rsp_in = avm_readdatavalid | (~POSTED_WRITES & avm_writeresponsevalid);
    // Responses with nothing outstanding are dropped rather than underflowing.
    assign dec    = rsp_in & any_out;

    assign rd_fwd = avm_readdatavalid & any_out;
    assign wr_fwd = POSTED_WRITES ? (issue & cmd_we_q)
                                  : (avm_writeresponsevalid & any_out);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd_valid_q   <= 1'b0;
            cmd_we_q      <= 1'b0;
            kind_q        <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            outstanding_q <= '0;
            rvalid_q      <= 1'b0;
            wresp_q       <= 1'b0;
            rdata_q       <= '0;
            resp_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            // A new request may reload the stage in the same cycle it issues.
            if (accept) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= bus_data_write;
                kind_q      <= bus_data_write;
                addr_q      <= bus_data_addr;
                be_q        <= bus_data_be;
                wdata_q     <= bus_data_wdata;
            end else if (issue) begin
                cmd_valid_q <= 1'b0;
            end

            outstanding_q <= outstanding_q + CW'(inc) - CW'(dec);

            rvalid_q <= rd_fwd;
            wresp_q  <= wr_fwd;
            if (rd_fwd) begin
                rdata_q <= avm_readdata;
                resp_q  <= avm_response;
            end else if (wr_fwd) begin
                resp_q  <= POSTED_WRITES ? 2'b00 : avm_response;
            end

            if (rsp_in && !any_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign avm_read       = cmd_valid_q & ~cmd_we_q;
    assign avm_write      = cmd_valid_q & cmd_we_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;

    assign bus_data_rvalid     = rvalid_q;
    assign bus_data_rdata      = rdata_q;
    assign bus_data_wrespvalid = wresp_q;
    assign bus_data_resp       = resp_q;
    assign proto_err_o         = err_q;

endmodule
